decode_cycle: RTL and testbench

//  Second stage of the 5-stage RV32I pipelined core. Consumes InstrD/PCD/PCPlus4D from the fetch stage.

---
 rtl/riscv_pkg.sv | 79 +++++++
 rtl/register_file.sv | 54 +++++
 rtl/decode_cycle.sv | 156 +++++++++++++++
 tb/tb_decode_cycle.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, control encodings and the ID/EX bundle.
// Imported by the decode stage and its register file.
package riscv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        alu_ctrl_t   alu_ctrl;
        logic        alu_src;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_ext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } id_ex_t;

    // sub only for R-type with funct7[5]; I-type shares the table but never subtracts
    function automatic alu_ctrl_t alu_from_funct(
        input logic [2:0] funct3,
        input logic       sub_ok
    );
        alu_ctrl_t a;
        case (funct3)
            F3_ADD:  a = sub_ok ? ALU_SUB : ALU_ADD;
            F3_SLT:  a = ALU_SLT;
            F3_OR:   a = ALU_OR;
            F3_AND:  a = ALU_AND;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: 2 async read ports, 1 write port,
// write-through bypass so decode sees the value being written back.
module register_file
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (wr_en && (wa == ra1)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (wr_en && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extend,
// and the ID/EX pipeline register feeding execute.
module decode_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rd_d;
    ctrl_t       ctrl_d;
    imm_src_t    imm_src;
    logic [31:0] imm_ext_d;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    id_ex_t      ex_q;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7_5 = InstrD[30];
    assign rd_d     = InstrD[11:7];
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];

    // Unknown opcodes (including all-zero) fall through as a bubble
    always_comb begin
        ctrl_d  = '0;
        imm_src = IMM_I;
        unique case (1'b1)
            opcode == OP_R: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = alu_from_funct(funct3, funct7_5);
            end
            opcode == OP_I: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_ctrl  = alu_from_funct(funct3, 1'b0);
            end
            opcode == OP_LW: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = RES_MEM;
            end
            opcode == OP_SW: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_src          = IMM_S;
            end
            opcode == OP_BEQ: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.alu_ctrl = ALU_SUB;
                imm_src         = IMM_B;
            end
            opcode == OP_JAL: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.result_src = RES_PC4;
                imm_src           = IMM_J;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_comb begin
        imm_ext_d = '0;
        unique case (imm_src)
            IMM_I: imm_ext_d = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S: imm_ext_d = {{20{InstrD[31]}}, InstrD[31:25],
                                InstrD[11:7]};
            IMM_B: imm_ext_d = {{20{InstrD[31]}}, InstrD[7],
                                InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J: imm_ext_d = {{12{InstrD[31]}}, InstrD[19:12],
                                InstrD[20], InstrD[30:21], 1'b0};
            default: imm_ext_d = '0;
        endcase
    end

    register_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .we  (RegWriteW),
        .wa  (RDW),
        .wd  (ResultW),
        .ra1 (Rs1D),
        .ra2 (Rs2D),
        .rd1 (rd1_d),
        .rd2 (rd2_d)
    );

    // Flush kills only control; data fields are captured regardless
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q <= '0;
        end else begin
            ex_q.ctrl     <= FlushE ? '0 : ctrl_d;
            ex_q.rd1      <= rd1_d;
            ex_q.rd2      <= rd2_d;
            ex_q.imm_ext  <= imm_ext_d;
            ex_q.rs1      <= Rs1D;
            ex_q.rs2      <= Rs2D;
            ex_q.rd       <= rd_d;
            ex_q.pc       <= PCD;
            ex_q.pc_plus4 <= PCPlus4D;
        end
    end

    assign RegWriteE   = ex_q.ctrl.reg_write;
    assign ResultSrcE  = ex_q.ctrl.result_src;
    assign MemWriteE   = ex_q.ctrl.mem_write;
    assign JumpE       = ex_q.ctrl.jump;
    assign BranchE     = ex_q.ctrl.branch;
    assign ALUControlE = ex_q.ctrl.alu_ctrl;
    assign ALUSrcE     = ex_q.ctrl.alu_src;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign ImmExtE     = ex_q.imm_ext;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: reset, decode, immediates,
// register file bypass/x0, flush and async mid-run reset.
module tb_decode_cycle;

    logic        clk;
    logic        rst;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        FlushE;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;

    int n_checks;
    int n_fail;

    decode_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .FlushE      (FlushE),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RegWriteE   (RegWriteE),
        .ResultSrcE  (ResultSrcE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        InstrD   = instr;
        PCD      = pc;
        PCPlus4D = pc + 32'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] ctrl_bits();
        return 32'({RegWriteE, ResultSrcE, MemWriteE, JumpE,
                    BranchE, ALUControlE, ALUSrcE});
    endfunction

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        FlushE    = 1'b0;
        RegWriteW = 1'b0;
        RDW       = 5'd0;
        ResultW   = 32'd0;
        drive(32'h00500093, 32'h100);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ctrl", ctrl_bits(), 32'd0);
        check("rst_imm", ImmExtE, 32'd0);
        check("rst_rd", 32'(RdE), 32'd0);
        check("rst_pc", PCE, 32'd0);
        check("rst_pc4", PCPlus4E, 32'd0);
        check("rst_rs1d", 32'(Rs1D), 32'd0);

        rst = 1'b1;
        for (int i = 1; i < 32; i++) begin
            drive((32'(i) << 20) | (32'(i) << 15) | 32'h33, 32'h200);
            tick();
            check("rf_init_rd1", RD1E, 32'd0);
            check("rf_init_rd2", RD2E, 32'd0);
        end

        // addi x1,x0,5
        drive(32'h00500093, 32'h300);
        tick();
        check("addi_ctrl", ctrl_bits(), 32'b1_00_0_0_0_000_1);
        check("addi_imm", ImmExtE, 32'd5);
        check("addi_rd", 32'(RdE), 32'd1);
        check("addi_pc", PCE, 32'h300);
        check("addi_pc4", PCPlus4E, 32'h304);

        // addi x1,x0,0x400 : funct7[5] set, still add
        drive(32'h40000093, 32'h304);
        tick();
        check("addi_nosub", 32'(ALUControlE), 32'b000);
        check("addi_imm2", ImmExtE, 32'h400);

        // add x3,x2,x2 with writeback to x2 in same cycle
        drive(32'h002101B3, 32'h308);
        RegWriteW = 1'b1;
        RDW       = 5'd2;
        ResultW   = 32'hDEADBEEF;
        check("rs1d_comb", 32'(Rs1D), 32'd2);
        check("rs2d_comb", 32'(Rs2D), 32'd2);
        tick();
        check("byp_rd1", RD1E, 32'hDEADBEEF);
        check("byp_rd2", RD2E, 32'hDEADBEEF);
        check("add_ctrl", ctrl_bits(), 32'b1_00_0_0_0_000_0);
        check("add_rs", {22'd0, Rs1E, Rs2E}, {22'd0, 5'd2, 5'd2});
        RegWriteW = 1'b0;
        tick();
        check("rf_x2_stored", RD1E, 32'hDEADBEEF);

        // sub x3,x2,x2
        drive(32'h402101B3, 32'h30C);
        tick();
        check("sub_alu", 32'(ALUControlE), 32'b001);

        // write to x0 ignored, bypass must not fire
        drive(32'h000001B3, 32'h310);
        RegWriteW = 1'b1;
        RDW       = 5'd0;
        ResultW   = 32'h1234;
        tick();
        check("x0_byp", RD1E, 32'd0);
        RegWriteW = 1'b0;
        tick();
        check("x0_read", RD1E, 32'd0);

        // lw x4,8(x2)
        drive(32'h00812203, 32'h314);
        tick();
        check("lw_ctrl", ctrl_bits(), 32'b1_01_0_0_0_000_1);
        check("lw_imm", ImmExtE, 32'd8);
        check("lw_rd1", RD1E, 32'hDEADBEEF);

        // beq offset -8
        drive(32'hFE000CE3, 32'h318);
        tick();
        check("beq_ctrl", ctrl_bits(), 32'b0_00_0_0_1_001_0);
        check("beq_imm", ImmExtE, 32'hFFFFFFF8);

        // jal x1,+2048
        drive(32'h001000EF, 32'h31C);
        tick();
        check("jal_ctrl", ctrl_bits(), 32'b1_10_0_1_0_000_0);
        check("jal_imm", ImmExtE, 32'h00000800);

        // bubble
        drive(32'h00000000, 32'h320);
        tick();
        check("bubble_ctrl", ctrl_bits(), 32'd0);

        // sw x5,4(x6) flushed, plus a write to x7 the same cycle
        drive(32'h00532223, 32'h324);
        FlushE    = 1'b1;
        RegWriteW = 1'b1;
        RDW       = 5'd7;
        ResultW   = 32'h77;
        tick();
        check("flush_ctrl", ctrl_bits(), 32'd0);
        check("flush_pc", PCE, 32'h324);
        check("flush_imm", ImmExtE, 32'd4);
        check("flush_rd", 32'(Rs2E), 32'd5);
        FlushE    = 1'b0;
        RegWriteW = 1'b0;
        tick();
        check("sw_ctrl", ctrl_bits(), 32'b0_00_1_0_0_000_1);
        check("sw_imm", ImmExtE, 32'd4);
        drive(32'h00038033, 32'h328);
        tick();
        check("flush_wr_x7", RD1E, 32'h77);

        // async reset mid-run
        drive(32'h001000EF, 32'h32C);
        tick();
        check("pre_rst_jump", 32'(JumpE), 32'd1);
        drive(32'h002101B3, 32'h330);
        #2 rst = 1'b0;
        #1;
        check("arst_ctrl", ctrl_bits(), 32'd0);
        check("arst_pc", PCE, 32'd0);
        check("arst_imm", ImmExtE, 32'd0);
        #1 rst = 1'b1;
        tick();
        check("post_rst_ctrl", ctrl_bits(), 32'b1_00_0_0_0_000_0);
        check("post_rst_x2", RD1E, 32'd0);
        check("post_rst_pc", PCE, 32'h330);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
